// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage feeding decode. Owns the fetch PC, issues word
//   requests over a valid/ready channel, accepts in-order responses, buffers
//   them in a 2-entry queue and presents one registered instruction/PC pair
//   per cycle. Responses belonging to a flushed path are discarded.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_stall            decode cannot accept; hold or_*
//   i_flush            redirect request (wins over stall)
//   i_redirect_pc      new PC, sampled with i_flush
//   o_imem_req_valid   request valid
//   o_imem_addr        word address of the request
//   i_imem_req_ready   memory accepts request on valid & ready
//   i_imem_rsp_valid   response word valid (in order)
//   i_imem_rsp_data    response word
//   or_inst, or_pc     registered instruction and its PC
//   or_valid           or_inst/or_pc hold a real instruction
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      drop_q, drop_d;
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] q_inst_q [2];
    logic [XLEN-1:0] q_inst_d [2];
    logic [XLEN-1:0] q_pc_q [2];
    logic [XLEN-1:0] q_pc_d [2];
    logic            or_valid_q, or_valid_d;
    logic [XLEN-1:0] or_inst_q, or_inst_d;
    logic [XLEN-1:0] or_pc_q, or_pc_d;

    logic            req_valid;
    logic            req_fire;
    logic            rsp_take;

    // Credit: requests in flight plus queued words may never exceed the
    // queue depth, so a stalled decode can always absorb every response.
    always_comb begin
        req_valid = i_rst_n && !i_flush &&
                    (({1'b0, outstanding_q} + {1'b0, count_q}) < 3'd2);
        req_fire  = req_valid && i_imem_req_ready;
        rsp_take  = i_imem_rsp_valid && !i_flush && (drop_q == 2'd0);
    end

    assign o_imem_req_valid = req_valid;
    assign o_imem_addr      = pc_q;
    assign or_inst          = or_inst_q;
    assign or_pc            = or_pc_q;
    assign or_valid         = or_valid_q;

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        q_inst_d      = q_inst_q;
        q_pc_d        = q_pc_q;
        or_valid_d    = or_valid_q;
        or_inst_d     = or_inst_q;
        or_pc_d       = or_pc_q;

        if (req_fire) begin
            outstanding_d = outstanding_d + 2'd1;
        end
        if (i_imem_rsp_valid) begin
            outstanding_d = outstanding_d - 2'd1;
        end

        if (i_flush) begin
            pc_d       = i_redirect_pc & ALIGN_MASK;
            rsp_pc_d   = i_redirect_pc & ALIGN_MASK;
            // Everything still outstanding after this cycle is stale.
            drop_d     = i_imem_rsp_valid ? (outstanding_q - 2'd1) : outstanding_q;
            count_d    = 2'd0;
            or_valid_d = 1'b0;
            or_inst_d  = NOP_INST;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (i_imem_rsp_valid && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (rsp_take) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end

            if (!i_stall) begin
                if (count_q != 2'd0) begin
                    or_valid_d  = 1'b1;
                    or_inst_d   = q_inst_q[0];
                    or_pc_d     = q_pc_q[0];
                    q_inst_d[0] = q_inst_q[1];
                    q_pc_d[0]   = q_pc_q[1];
                    if (rsp_take) begin
                        // Post-pop tail slot: index 0 when one entry was held, 1 when two.
                        q_inst_d[count_q[1]] = i_imem_rsp_data;
                        q_pc_d[count_q[1]]   = rsp_pc_q;
                    end else begin
                        count_d = count_q - 2'd1;
                    end
                end else if (rsp_take) begin
                    or_valid_d = 1'b1;
                    or_inst_d  = i_imem_rsp_data;
                    or_pc_d    = rsp_pc_q;
                end else begin
                    or_valid_d = 1'b0;
                    or_inst_d  = NOP_INST;
                end
            end else if (rsp_take) begin
                // Credit guarantees count_q < 2 here.
                q_inst_d[count_q[0]] = i_imem_rsp_data;
                q_pc_d[count_q[0]]   = rsp_pc_q;
                count_d              = count_q + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= RESET_PC & ALIGN_MASK;
            rsp_pc_q      <= RESET_PC & ALIGN_MASK;
            outstanding_q <= 2'd0;
            drop_q        <= 2'd0;
            count_q       <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
            or_valid_q    <= 1'b0;
            or_inst_q     <= NOP_INST;
            or_pc_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            q_inst_q      <= q_inst_d;
            q_pc_q        <= q_pc_d;
            or_valid_q    <= or_valid_d;
            or_inst_q     <= or_inst_d;
            or_pc_q       <= or_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural memory returns
//   addr ^ KEY in order after a programmable latency. The reference model
//   only tracks the program-order PC stream: every instruction delivered to
//   decode must be the next PC of the current path with data PC ^ KEY,
//   outputs freeze under stall, and a flush restarts the path.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_addr;
    logic        i_imem_req_ready = 1'b0;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic [31:0] or_inst;
    logic [31:0] or_pc;
    logic        or_valid;

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_redirect_pc   (i_redirect_pc),
        .o_imem_req_valid(o_imem_req_valid),
        .o_imem_addr     (o_imem_addr),
        .i_imem_req_ready(i_imem_req_ready),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data (i_imem_rsp_data),
        .or_inst         (or_inst),
        .or_pc           (or_pc),
        .or_valid        (or_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_t;

    mem_t        mem_q[$];
    int unsigned cyc;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_valid  = 0;

    // stimulus knobs
    bit          k_stall, k_flush, k_ready;
    logic [31:0] k_redir;
    int unsigned k_lat, k_rsp_pct;

    // reference model
    logic [31:0] exp_req_pc, exp_out_pc;
    logic        hold_valid;
    logic [31:0] hold_inst, hold_pc;
    bit          new_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle; entered and left at the falling edge.
    task automatic step();
        bit   fl, st;
        mem_t m;
        fl = k_flush;
        st = k_stall && !k_flush;
        i_stall          = k_stall;
        i_flush          = k_flush;
        i_redirect_pc    = k_redir;
        i_imem_req_ready = k_ready;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < k_rsp_pct) begin
            m = mem_q.pop_front();
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = m.addr ^ KEY;
        end
        #1;
        if (fl) check("req_in_flush", 32'(o_imem_req_valid), 32'd0);
        if (o_imem_req_valid) begin
            check("req_addr", o_imem_addr, exp_req_pc);
            if (k_ready) begin
                mem_q.push_back('{addr: o_imem_addr, due: cyc + k_lat});
                exp_req_pc = exp_req_pc + 32'd4;
                check("inflight_le2", 32'(mem_q.size() <= 2), 32'd1);
            end
        end
        if (fl) begin
            exp_req_pc = k_redir & ~32'd3;
            exp_out_pc = k_redir & ~32'd3;
        end
        @(posedge i_clk);
        cyc++;
        #1;
        new_valid = 1'b0;
        if (fl) begin
            check("flush_bubble", 32'(or_valid), 32'd0);
        end else if (st) begin
            check("stall_valid", 32'(or_valid), 32'(hold_valid));
            check("stall_pc", or_pc, hold_pc);
            check("stall_inst", or_inst, hold_inst);
        end else if (or_valid) begin
            check("out_pc", or_pc, exp_out_pc);
            check("out_inst", or_inst, exp_out_pc ^ KEY);
            exp_out_pc = exp_out_pc + 32'd4;
            n_valid++;
            new_valid = 1'b1;
        end
        if (!or_valid) check("bubble_nop", or_inst, NOP);
        hold_valid = or_valid;
        hold_inst  = or_inst;
        hold_pc    = or_pc;
        @(negedge i_clk);
    endtask

    task automatic apply_reset();
        #2;
        i_rst_n          = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_flush          = 1'b0;
        i_stall          = 1'b0;
        mem_q.delete();
        #1;
        check("rst_valid", 32'(or_valid), 32'd0);
        check("rst_inst", or_inst, NOP);
        check("rst_pc", or_pc, 32'd0);
        check("rst_req", 32'(o_imem_req_valid), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        cyc        = 0;
        exp_req_pc = RST_PC;
        exp_out_pc = RST_PC;
        hold_valid = 1'b0;
        hold_inst  = NOP;
        hold_pc    = '0;
    endtask

    task automatic wait_valid(input string tag, output logic [31:0] pc);
        bit got;
        got = 1'b0;
        pc  = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (new_valid) begin
                got = 1'b1;
                pc  = or_pc;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic set_benign();
        k_stall = 1'b0; k_flush = 1'b0; k_ready = 1'b1;
        k_redir = '0;   k_lat = 1;      k_rsp_pct = 100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          n0;
        bit          found;

        set_benign();
        apply_reset();

        // Back-to-back stream with a 1-cycle memory.
        for (int i = 0; i < 12; i++) begin
            step();
            if (cyc == 1) check("first_latency", 32'(or_valid), 32'd0);
            else          check("stream_valid", 32'(or_valid), 32'd1);
        end

        // Stall for 3 cycles mid-stream.
        k_stall = 1'b1;
        repeat (3) step();
        k_stall = 1'b0;
        repeat (6) step();

        // Request backpressure for 4 cycles.
        k_ready = 1'b0;
        repeat (4) step();
        check("bp_drained", 32'(or_valid), 32'd0);
        k_ready = 1'b1;
        repeat (6) step();

        // Flush penalty with a 1-cycle memory.
        k_flush = 1'b1; k_redir = 32'h0000_0400;
        step();
        k_flush = 1'b0;
        step();
        check("flush_pen_f1", 32'(or_valid), 32'd0);
        step();
        check("flush_pen_f2", 32'(or_valid), 32'd1);
        check("flush_pen_pc", or_pc, 32'h0000_0400);

        // Flush with two requests in flight on a 3-cycle memory.
        k_lat = 3;
        repeat (8) step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1'b1;
            else step();
        end
        check("two_inflight", 32'(found), 32'd1);
        k_flush = 1'b1; k_redir = 32'h0000_2002;
        step();
        k_flush = 1'b0;
        wait_valid("redir2000", pc);
        check("redir2000_pc", pc, 32'h0000_2000);
        repeat (8) step();

        // Flush and stall together.
        k_lat = 1;
        k_stall = 1'b1; k_flush = 1'b1; k_redir = 32'h0000_3000;
        step();
        k_stall = 1'b0; k_flush = 1'b0;
        wait_valid("redir3000", pc);
        check("redir3000_pc", pc, 32'h0000_3000);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            k_stall   = ($urandom_range(3) == 0);
            k_ready   = ($urandom_range(3) != 0);
            k_flush   = ($urandom_range(29) == 0);
            k_redir   = $urandom;
            k_lat     = $urandom_range(4, 1);
            k_rsp_pct = 70;
            step();
        end
        set_benign();
        repeat (6) step();
        n0 = n_valid;
        repeat (20) step();
        check("drain_progress", 32'((n_valid - n0) >= 15), 32'd1);

        // Async reset mid-burst, then wrap-around redirect.
        repeat (5) step();
        apply_reset();
        k_flush = 1'b1; k_redir = 32'hFFFF_FFFC;
        step();
        k_flush = 1'b0;
        wait_valid("wrap0", pc);
        check("wrap_pc0", pc, 32'hFFFF_FFFC);
        wait_valid("wrap1", pc);
        check("wrap_pc1", pc, 32'h0000_0000);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter, issues word requests to instruction memory over a valid/ready request channel and an in-order response channel, and buffers returned words in a 2-entry queue. It presents one registered instruction/PC pair per cycle to decode. It honours the pipeline `i_stall` and `i_flush`/redirect signals and discards in-flight responses that belong to the flushed path.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] are ignored.
- `NOP_INST`, default `32'h0000_0013`: value driven on `or_inst` whenever `or_valid` = 0.
- `i_clk` in 1: CPU clock; all state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_stall` in 1: decode cannot accept; hold `or_*`.
- `i_flush` in 1: redirect request; wins over `i_stall`.
- `i_redirect_pc` in `XLEN`: new PC, sampled when `i_flush` = 1.
- `o_imem_req_valid` out 1: request valid.
- `o_imem_addr` out `XLEN`: word address (PC); bits [1:0] are always 0.
- `i_imem_req_ready` in 1: memory accepts the request when valid & ready.
- `i_imem_rsp_valid` in 1: response word valid; responses return in order, at least 1 cycle after acceptance.
- `i_imem_rsp_data` in `XLEN`: instruction word.
- `or_inst` out `XLEN`: instruction to decode.
- `or_pc` out `XLEN`: PC of `or_inst`.
- `or_valid` out 1: `or_inst`/`or_pc` hold a real instruction.

## Operation
- **Reset.** Asserting `i_rst_n` low immediately clears state:
  - fetch PC = `RESET_PC & ~3`, queue empty, `outstanding` = 0, `drop` = 0.
  - `o_imem_req_valid` = 0, `or_valid` = 0, `or_inst` = `NOP_INST`, `or_pc` = 0.
- **Request issue.** `o_imem_req_valid` = 1 when out of reset, `i_flush` = 0, and `outstanding + queue_count < 2`.
  - On handshake (valid & ready): PC += 4, wrapping modulo 2^32, and `outstanding` += 1.
  - `o_imem_addr` = PC, held stable while valid is high and ready is low.
- **Response.** On `i_imem_rsp_valid`, `outstanding` -= 1.
  - If `drop` > 0: the word is discarded and `drop` -= 1.
  - Otherwise the word is tagged with its PC, taken from the response-PC counter, which then advances by 4.
- **Output register.** Loads when `i_stall` = 0. Source priority:
  - queue head (pop), else
  - the arriving response (fall-through, only when the queue is empty), else
  - bubble: `or_valid` = 0, `or_inst` = `NOP_INST`, `or_pc` unchanged.
- **Stall.** When `i_stall` = 1, `or_*` are held and arriving responses are pushed into the queue. The credit rule guarantees the queue never overflows.
- **Flush.** In the `i_flush` cycle:
  - fetch PC and response-PC are set to `i_redirect_pc & ~3`.
  - the queue is cleared.
  - `drop` = `outstanding` after this cycle's response is counted; a response arriving in the flush cycle is itself discarded.
  - `or_valid` <= 0 and `or_inst` <= `NOP_INST`.
  - no request is issued in the flush cycle; fetching resumes on the next cycle.
- **Simultaneous events.**
  - flush + stall: flush behaviour.
  - flush + request handshake: cannot occur, because valid is 0 during flush.
  - push + pop in the same cycle: queue count unchanged.
- **Counter widths.** `outstanding` and `drop` are 2 bits each; both are ≤ 2 by construction.
- **PC arithmetic.** Unsigned 32-bit; `32'hFFFF_FFFC` + 4 = `32'h0000_0000`.

## Timing
- **Ready and 1-cycle memory.** Request at edge N, response valid in cycle N+1, `or_valid` = 1 after edge N+1.
  - Steady state: 1 instruction per cycle.
- **First valid instruction.** With `i_imem_req_ready` tied to 1 and a 1-cycle memory, reset is released and the first request handshake completes at edge 1. The first `or_valid` appears after edge 2.
- **Queue latency.** Queue pop to output register: 1 edge.
  - After a stall clears, the queued word appears after the next edge.
- **Flush penalty.** Flush at edge F, new request at edge F+1, first redirected `or_valid` after edge F+2.
- **Dropped responses.** Responses for pre-flush requests never reach `or_*`, regardless of how late they arrive.

## Test plan
- **Reset and stream.** Release reset with `RESET_PC` = `0x100` and a 1-cycle memory returning `addr ^ 0xA5A5_0000`.
  - Required: `or_pc` = 0x100, 0x104, 0x108… on consecutive cycles after edge 2, with matching `or_inst`.
- **Stall.** Hold `i_stall` for 3 cycles mid-stream.
  - Required: `or_*` frozen; at most 2 requests outstanding or queued; no word lost or duplicated; sequence resumes at the next PC.
- **Flush with in-flight requests.** Memory latency 3, `i_flush` with `i_redirect_pc` = `0x2002`.
  - Required: 2 stale responses discarded; next `or_valid` has `or_pc` = `0x2000`.
- **Flush + stall same cycle.** Assert both together.
  - Required: flush wins; `or_valid` = 0 next cycle; fetch redirected.
- **Backpressure.** `i_imem_req_ready` = 0 for 4 cycles.
  - Required: `o_imem_addr` stable; `or_valid` = 0 once the queue drains; no PC skip.
- **Async reset mid-burst and wrap-around.** Assert `i_rst_n` = 0 between edges, then redirect to `0xFFFF_FFFC` and run.
  - Required: outputs reset immediately, without waiting for a clock edge.
  - Required after redirect: `or_pc` sequence is `0xFFFF_FFFC` then `0x0000_0000`.
